// File: rtl/user_logic_pkg.sv
// Shared constants for the record unpacker: header field placement, FSM states,
// status register map and counter geometry.
package user_logic_pkg;

   // Header fields, given as the index of the NofBits-wide lane they occupy
   localparam int HDR_MAGIC_FIELD = 3;
   localparam int HDR_LEN_FIELD   = 2;
   localparam int HDR_SEQ_FIELD   = 1;
   localparam int HDR_SEQ_W       = 16;
   localparam int HDR_TRIG_LSB    = 0;
   localparam int HDR_TRIG_W      = 4;

   typedef enum logic {
      HUNT,
      PAYLOAD
   } state_t;

   localparam int REG_REC_DONE = 0;
   localparam int REG_SYNC_ERR = 1;
   localparam int REG_LEN_ERR  = 2;
   localparam int REG_SEQ_ERR  = 3;
   localparam int NUM_STATUS   = 4;

   localparam int             CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/user_logic_sat_counter.sv
// 16-bit saturating event counter; clear takes priority over increment.
module user_logic_sat_counter
   import user_logic_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/user_logic_data_unpacking.sv
// Unpacks header/payload records of 4xNofBits words into four signed samples per
// clock, with trigger vector on the first payload word and framing statistics.
//
// state   | meaning
// HUNT    | waiting for a header with valid magic and length
// PAYLOAD | emitting payload words until the record length is consumed
module user_logic_data_unpacking
   import user_logic_pkg::*;
#(
   parameter int          NofBits             = 16,
   parameter int          NofUserRegistersOut = 4,
   parameter int          MaxRecordWords      = 1024,
   parameter logic [15:0] HeaderMagic         = 16'hA55A
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [4*NofBits-1:0]              word_i,
   input  logic                              word_valid_i,
   output logic signed [NofBits-1:0]         y0_o,
   output logic signed [NofBits-1:0]         y0z_o,
   output logic signed [NofBits-1:0]         y1_o,
   output logic signed [NofBits-1:0]         y1z_o,
   output logic                              data_valid_o,
   output logic [3:0]                        trigger_vector_o,
   input  logic [16*8-1:0]                   user_register_i,
   output logic [16*NofUserRegistersOut-1:0] user_register_o
);

   localparam int             N       = NofBits;
   localparam logic [N-1:0]   MAGIC_N = N'(HeaderMagic);
   localparam logic [N-1:0]   MAX_LEN = N'(MaxRecordWords);

   logic enable, clr;
   assign enable = user_register_i[0];
   assign clr    = user_register_i[1];

   logic unused_ctrl;
   assign unused_ctrl = ^user_register_i[16*8-1:2];

   logic [N-1:0]            magic_f, len_f;
   logic [HDR_SEQ_W-1:0]    seq_f;
   logic [HDR_TRIG_W-1:0]   trig_f;
   assign magic_f = word_i[N*HDR_MAGIC_FIELD +: N];
   assign len_f   = word_i[N*HDR_LEN_FIELD +: N];
   assign seq_f   = word_i[N*HDR_SEQ_FIELD +: HDR_SEQ_W];
   assign trig_f  = word_i[HDR_TRIG_LSB +: HDR_TRIG_W];

   state_t                state, state_nxt;
   logic [N-1:0]          remaining, remaining_nxt;
   logic [HDR_TRIG_W-1:0] trig_lat, trig_lat_nxt;
   logic                  first_word, first_word_nxt;
   logic                  first_hdr, first_hdr_nxt;
   logic [HDR_SEQ_W-1:0]  expected, expected_nxt;
   logic                  emit, inc_rec, inc_sync, inc_len, inc_seq;

   always_comb begin
      state_nxt      = state;
      remaining_nxt  = remaining;
      trig_lat_nxt   = trig_lat;
      first_word_nxt = first_word;
      first_hdr_nxt  = first_hdr;
      expected_nxt   = expected;
      emit           = 1'b0;
      inc_rec        = 1'b0;
      inc_sync       = 1'b0;
      inc_len        = 1'b0;
      inc_seq        = 1'b0;

      if (!enable) begin
         state_nxt      = HUNT;
         first_word_nxt = 1'b0;
      end else if (word_valid_i) begin
         case (state)
            HUNT: begin
               if (magic_f != MAGIC_N) begin
                  inc_sync = 1'b1;
               end else if ((len_f == '0) || (len_f > MAX_LEN)) begin
                  inc_len = 1'b1;
               end else begin
                  state_nxt      = PAYLOAD;
                  remaining_nxt  = len_f;
                  trig_lat_nxt   = trig_f;
                  first_word_nxt = 1'b1;
                  first_hdr_nxt  = 1'b0;
                  expected_nxt   = seq_f + 16'd1;
                  inc_seq        = !first_hdr && (seq_f != expected);
               end
            end
            PAYLOAD: begin
               emit           = 1'b1;
               first_word_nxt = 1'b0;
               remaining_nxt  = remaining - 1'b1;
               if (remaining == 1) begin
                  inc_rec   = 1'b1;
                  state_nxt = HUNT;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end

      // A clear re-arms the first-header exemption even if a header lands now
      if (clr) begin
         first_hdr_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state            <= HUNT;
         remaining        <= '0;
         trig_lat         <= '0;
         first_word       <= 1'b0;
         first_hdr        <= 1'b1;
         expected         <= '0;
         y0_o             <= '0;
         y0z_o            <= '0;
         y1_o             <= '0;
         y1z_o            <= '0;
         data_valid_o     <= 1'b0;
         trigger_vector_o <= '0;
      end else begin
         state            <= state_nxt;
         remaining        <= remaining_nxt;
         trig_lat         <= trig_lat_nxt;
         first_word       <= first_word_nxt;
         first_hdr        <= first_hdr_nxt;
         expected         <= expected_nxt;
         data_valid_o     <= emit;
         trigger_vector_o <= (emit && first_word) ? trig_lat : '0;
         if (!enable) begin
            y0_o  <= '0;
            y0z_o <= '0;
            y1_o  <= '0;
            y1z_o <= '0;
         end else if (emit) begin
            y0_o  <= word_i[0   +: N];
            y0z_o <= word_i[N   +: N];
            y1_o  <= word_i[2*N +: N];
            y1z_o <= word_i[3*N +: N];
         end
      end
   end

   logic [NUM_STATUS-1:0] cnt_inc;
   logic [CNT_W-1:0]      cnt_val [NUM_STATUS];

   assign cnt_inc[REG_REC_DONE] = inc_rec;
   assign cnt_inc[REG_SYNC_ERR] = inc_sync;
   assign cnt_inc[REG_LEN_ERR]  = inc_len;
   assign cnt_inc[REG_SEQ_ERR]  = inc_seq;

   for (genvar g = 0; g < NUM_STATUS; g++) begin : g_cnt
      user_logic_sat_counter u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr   (clr),
         .inc   (cnt_inc[g]),
         .count (cnt_val[g])
      );
   end

   always_comb begin
      user_register_o = '0;
      for (int i = 0; i < NUM_STATUS; i++) begin
         user_register_o[i*16 +: 16] = cnt_val[i];
      end
   end

endmodule

// File: tb/tb_user_logic_data_unpacking.sv
// Scoreboard bench for the record unpacker: stimulus pushes expected samples,
// a negedge monitor pops and compares on every data_valid_o.
module tb_user_logic_data_unpacking;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   word;
   logic          word_valid;
   logic [127:0]  ureg;
   logic signed [15:0] y0, y0z, y1, y1z;
   logic          dv;
   logic [3:0]    trig;
   logic [63:0]   ureg_o;

   always #5 clk = ~clk;

   user_logic_data_unpacking dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .word_i           (word),
      .word_valid_i     (word_valid),
      .y0_o             (y0),
      .y0z_o            (y0z),
      .y1_o             (y1),
      .y1z_o            (y1z),
      .data_valid_o     (dv),
      .trigger_vector_o (trig),
      .user_register_i  (ureg),
      .user_register_o  (ureg_o)
   );

   typedef struct packed {
      logic [15:0] y0, y0z, y1, y1z;
      logic [3:0]  trig;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   nvalid   = 0;
   int   n0;

   function automatic logic [63:0] pay(input logic [15:0] b);
      return {b + 16'd3, b + 16'd2, b + 16'd1, b};
   endfunction

   function automatic logic [63:0] hdr(input logic [15:0] len, input logic [15:0] cnt,
                                       input logic [3:0] t);
      return {16'hA55A, len, cnt, 12'h000, t};
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [63:0] w, input logic v);
      @(posedge clk);
      #1;
      word       = w;
      word_valid = v;
   endtask

   task automatic push_pay(input logic [15:0] b, input logic [3:0] t);
      q.push_back({b, b + 16'd1, b + 16'd2, b + 16'd3, t});
   endtask

   task automatic settle();
      repeat (2) drive(64'h0, 1'b0);
   endtask

   task automatic do_clear();
      ureg = 128'd3;
      drive(64'h0, 1'b0);
      ureg = 128'd1;
   endtask

   task automatic record(input int len, input logic [15:0] cnt, input logic [3:0] t,
                         input logic [15:0] base, input logic clr_last);
      drive(hdr(16'(len), cnt, t), 1'b1);
      for (int i = 0; i < len; i++) begin
         drive(pay(base + 16'(4*i)), 1'b1);
         if (clr_last && (i == len - 1)) ureg = 128'd3;
         push_pay(base + 16'(4*i), (i == 0) ? t : 4'h0);
      end
   endtask

   task automatic record_gappy(input int len, input logic [15:0] cnt, input logic [3:0] t,
                               input logic [15:0] base);
      drive(hdr(16'(len), cnt, t), 1'b1);
      for (int i = 0; i < len; i++) begin
         if (i > 0) begin
            drive(64'h0, 1'b0);
            @(posedge clk);
            #1;
            check("gap_dv", {79'h0, dv}, 80'h0);
            check("gap_hold_y0", {64'h0, y0}, {64'h0, base + 16'(4*(i-1))});
         end else begin
            @(posedge clk);
            #1;
         end
         word       = pay(base + 16'(4*i));
         word_valid = 1'b1;
         push_pay(base + 16'(4*i), (i == 0) ? t : 4'h0);
      end
   endtask

   function automatic logic [15:0] rreg(input int idx);
      return ureg_o[idx*16 +: 16];
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (dv) begin
            nvalid++;
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=%h_%h_%h_%h required=no_output", y1z, y1, y0z, y0);
            end else begin
               mon_e = q.pop_front();
               check("sample", {12'h0, y0, y0z, y1, y1z, trig}, {12'h0, mon_e});
            end
         end else if (trig != 4'h0) begin
            checks++;
            failures++;
            $display("FAIL stray_trigger actual=%h required=0", trig);
         end
      end
   end

   initial begin
      rst        = 1'b0;
      word       = 64'h0;
      word_valid = 1'b0;
      ureg       = 128'd1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dv", {79'h0, dv}, 80'h0);
      check("rst_samples", {16'h0, y0, y0z, y1, y1z}, 80'h0);
      check("rst_trig", {76'h0, trig}, 80'h0);
      check("rst_regs", {16'h0, ureg_o}, 80'h0);
      rst = 1'b1;

      // basic record
      n0 = nvalid;
      record(3, 16'd0, 4'b0101, 16'd1, 1'b0);
      settle();
      check("t1_rec_done", {64'h0, rreg(0)}, 80'd1);
      check("t1_nvalid", 80'(nvalid - n0), 80'd3);

      // sequence check
      do_clear();
      check("clr_regs", {16'h0, ureg_o}, 80'h0);
      record(2, 16'd7, 4'h0, 16'd100, 1'b0);
      record(2, 16'd9, 4'h0, 16'd200, 1'b0);
      settle();
      check("t2_seq_err", {64'h0, rreg(3)}, 80'd1);
      check("t2_rec_done", {64'h0, rreg(0)}, 80'd2);
      record(2, 16'd10, 4'h3, 16'd300, 1'b0);
      settle();
      check("t2_seq_err_hold", {64'h0, rreg(3)}, 80'd1);
      check("t2_rec_done3", {64'h0, rreg(0)}, 80'd3);

      // garbage then header
      do_clear();
      repeat (5) drive(64'h1234_1234_1234_1234, 1'b1);
      record(1, 16'd0, 4'h3, 16'h0050, 1'b0);
      settle();
      check("t3_sync_err", {64'h0, rreg(1)}, 80'd5);
      check("t3_rec_done", {64'h0, rreg(0)}, 80'd1);

      // length bounds
      do_clear();
      n0 = nvalid;
      drive(hdr(16'd0, 16'd0, 4'h1), 1'b1);
      drive(hdr(16'd1025, 16'd0, 4'h1), 1'b1);
      settle();
      check("t4_len_err", {64'h0, rreg(2)}, 80'd2);
      check("t4_no_valid", 80'(nvalid - n0), 80'd0);
      record(1024, 16'd5, 4'h2, 16'h1000, 1'b0);
      settle();
      check("t4_max_rec", {64'h0, rreg(0)}, 80'd1);
      check("t4_max_nvalid", 80'(nvalid - n0), 80'd1024);
      check("t4_len_err_hold", {64'h0, rreg(2)}, 80'd2);

      // word_valid toggled in payload
      do_clear();
      n0 = nvalid;
      record_gappy(4, 16'd0, 4'hA, 16'h2000);
      settle();
      check("t5_nvalid", 80'(nvalid - n0), 80'd4);
      check("t5_rec_done", {64'h0, rreg(0)}, 80'd1);

      // enable dropped mid-record
      do_clear();
      drive(hdr(16'd4, 16'd0, 4'h6), 1'b1);
      drive(pay(16'h2100), 1'b1);
      push_pay(16'h2100, 4'h6);
      drive(pay(16'h2104), 1'b1);
      push_pay(16'h2104, 4'h0);
      @(posedge clk);
      #1;
      ureg       = 128'd0;
      word       = pay(16'h2108);
      word_valid = 1'b1;
      @(posedge clk);
      #1;
      check("t6_off_dv", {79'h0, dv}, 80'h0);
      check("t6_off_samples", {16'h0, y0, y0z, y1, y1z}, 80'h0);
      check("t6_off_rec_done", {64'h0, rreg(0)}, 80'd0);
      ureg       = 128'd1;
      word_valid = 1'b0;
      record(2, 16'd1, 4'h9, 16'h3000, 1'b0);
      settle();
      check("t6_resume_rec", {64'h0, rreg(0)}, 80'd1);
      check("t6_seq_err", {64'h0, rreg(3)}, 80'd0);

      // clear coinciding with record end
      record(2, 16'd2, 4'h0, 16'h4000, 1'b1);
      drive(64'h0, 1'b0);
      ureg = 128'd1;
      settle();
      check("t7_clr_wins", {64'h0, rreg(0)}, 80'd0);

      settle();
      check("queue_empty", 80'(q.size()), 80'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
